// File: rtl/matmul_mem_responder_pkg.sv
// Shared widths, region codes and address-decode helpers for the matmul memory responder.
package matmul_pkg;
   localparam int ADDR_W  = 10;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 16;
   localparam int IDX_W   = $clog2(DEPTH);
   localparam int C_WORDS = 4;

   localparam logic [1:0] REGION_A   = 2'b00;
   localparam logic [1:0] REGION_B   = 2'b01;
   localparam logic [1:0] REGION_C   = 2'b10;
   localparam logic [1:0] REGION_BAD = 2'b11;

   localparam logic [ADDR_W-1:0] BASE_A = 10'h000;
   localparam logic [ADDR_W-1:0] BASE_B = 10'h100;
   localparam logic [ADDR_W-1:0] BASE_C = 10'h200;

   // Bits between the region select and the word index must be clear.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-3:IDX_W] == '0;
   endfunction

   function automatic logic addr_ok(input logic [ADDR_W-1:0] a, input logic [1:0] region);
      return (a[ADDR_W-1 -: 2] == region) && in_range(a);
   endfunction
endpackage

// File: rtl/matmul_mem_responder_if.sv
// Engine A/B/C memory ports plus host access port of the matmul memory responder.
interface matmul_mem_responder_if;
   import matmul_pkg::*;

   logic              mem_read_en_A;
   logic [ADDR_W-1:0] mem_addr_A;
   logic [DATA_W-1:0] mem_data_A;
   logic              mem_read_en_B;
   logic [ADDR_W-1:0] mem_addr_B;
   logic [DATA_W-1:0] mem_data_B;
   logic              mem_write_en_C;
   logic [ADDR_W-1:0] mem_addr_C;
   logic [DATA_W-1:0] mem_data_C;
   logic              host_req;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_gnt;
   logic [DATA_W-1:0] host_rdata;
   logic              host_rvalid;
   logic              c_done;
   logic              err_addr;
   logic              err_clr;

   modport slave (
      input  mem_read_en_A, mem_addr_A, mem_read_en_B, mem_addr_B,
             mem_write_en_C, mem_addr_C, mem_data_C,
             host_req, host_we, host_addr, host_wdata, err_clr,
      output mem_data_A, mem_data_B, host_gnt, host_rdata, host_rvalid, c_done, err_addr
   );

   modport master (
      output mem_read_en_A, mem_addr_A, mem_read_en_B, mem_addr_B,
             mem_write_en_C, mem_addr_C, mem_data_C,
             host_req, host_we, host_addr, host_wdata, err_clr,
      input  mem_data_A, mem_data_B, host_gnt, host_rdata, host_rvalid, c_done, err_addr
   );
endinterface

// File: rtl/matmul_mem_responder_ram.sv
// One region of word storage: single write port, single registered read port, no reset.
module mm_region_ram #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end
endmodule

// File: rtl/matmul_mem_responder.sv
// Serves the matmul engine's A/B read and C write ports from three RAM regions, with a
// lower-priority host port for preload/readback, a C-write completion pulse and a sticky address error.
module matmul_mem_responder
   import matmul_pkg::*;
#(
   parameter int C_WORDS = matmul_pkg::C_WORDS
) (
   input  logic                   clk,
   input  logic                   rst,
   matmul_mem_responder_if.slave  bus
);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_RESP = 1'b1;
   localparam int NREG  = 3;
   localparam int CNT_W = $clog2(C_WORDS + 1);

   logic a_ok, b_ok, c_ok, eng_any, host_ok, host_gnt, host_wr, host_rd, err_set, c_wr;
   logic [1:0] host_reg;
   logic [IDX_W-1:0] host_idx;
   logic [0:0] state;
   logic [1:0] resp_reg;
   logic resp_ok;
   logic [CNT_W-1:0] c_wr_cnt;
   logic [NREG-1:0] we, re;
   logic [NREG-1:0][IDX_W-1:0] waddr, raddr;
   logic [NREG-1:0][DATA_W-1:0] wdata, rdata;
   logic [1:0] eng_rd, eng_ok, fresh;
   logic [1:0][DATA_W-1:0] hold, dout;

   assign a_ok    = addr_ok(bus.mem_addr_A, REGION_A);
   assign b_ok    = addr_ok(bus.mem_addr_B, REGION_B);
   assign c_ok    = addr_ok(bus.mem_addr_C, REGION_C);
   assign eng_any = bus.mem_read_en_A | bus.mem_read_en_B | bus.mem_write_en_C;
   assign c_wr    = bus.mem_write_en_C & c_ok;

   assign host_reg = bus.host_addr[ADDR_W-1 -: 2];
   assign host_idx = bus.host_addr[IDX_W-1:0];
   assign host_ok  = (host_reg != REGION_BAD) && in_range(bus.host_addr);
   assign host_gnt = bus.host_req & ~eng_any & (state == ST_IDLE);
   assign host_wr  = host_gnt & bus.host_we & host_ok;
   assign host_rd  = host_gnt & ~bus.host_we;
   assign bus.host_gnt = host_gnt;

   // Host drives all ports by default; engine accesses override (host is never granted alongside).
   always_comb begin
      for (int r = 0; r < NREG; r++) begin
         we[r]    = host_wr && (host_reg == 2'(r));
         re[r]    = host_rd && host_ok && (host_reg == 2'(r));
         waddr[r] = host_idx;
         raddr[r] = host_idx;
         wdata[r] = bus.host_wdata;
      end
      if (bus.mem_read_en_A && a_ok) begin
         re[0]    = 1'b1;
         raddr[0] = bus.mem_addr_A[IDX_W-1:0];
      end
      if (bus.mem_read_en_B && b_ok) begin
         re[1]    = 1'b1;
         raddr[1] = bus.mem_addr_B[IDX_W-1:0];
      end
      if (c_wr) begin
         we[2]    = 1'b1;
         waddr[2] = bus.mem_addr_C[IDX_W-1:0];
         wdata[2] = bus.mem_data_C;
      end
   end

   for (genvar r = 0; r < NREG; r++) begin : g_ram
      mm_region_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
         .clk(clk), .we(we[r]), .waddr(waddr[r]), .wdata(wdata[r]),
         .re(re[r]), .raddr(raddr[r]), .rdata(rdata[r])
      );
   end

   // Engine read data: live RAM output for one cycle after a good read, then a held copy,
   // so later host reads of the same region do not disturb mem_data_X.
   assign eng_rd = {bus.mem_read_en_B, bus.mem_read_en_A};
   assign eng_ok = {b_ok, a_ok};
   always_comb for (int r = 0; r < 2; r++) dout[r] = fresh[r] ? rdata[r] : hold[r];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fresh <= '0;
         hold  <= '0;
      end else begin
         for (int r = 0; r < 2; r++) begin
            fresh[r] <= eng_rd[r] & eng_ok[r];
            hold[r]  <= eng_rd[r] ? '0 : dout[r];
         end
      end
   end

   assign bus.mem_data_A = dout[0];
   assign bus.mem_data_B = dout[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         resp_reg <= REGION_A;
         resp_ok  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (host_rd) begin
               state    <= ST_RESP;
               resp_reg <= host_reg;
               resp_ok  <= host_ok;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.host_rvalid = (state == ST_RESP);
   always_comb begin
      bus.host_rdata = '0;
      if (state == ST_RESP && resp_ok) begin
         case (resp_reg)
            REGION_A: bus.host_rdata = rdata[0];
            REGION_B: bus.host_rdata = rdata[1];
            default:  bus.host_rdata = rdata[2];
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_wr_cnt   <= '0;
         bus.c_done <= 1'b0;
      end else begin
         bus.c_done <= 1'b0;
         if (c_wr) begin
            if (c_wr_cnt == CNT_W'(C_WORDS - 1)) begin
               c_wr_cnt   <= '0;
               bus.c_done <= 1'b1;
            end else begin
               c_wr_cnt <= c_wr_cnt + 1'b1;
            end
         end
      end
   end

   assign err_set = (bus.mem_read_en_A & ~a_ok) | (bus.mem_read_en_B & ~b_ok)
                  | (bus.mem_write_en_C & ~c_ok) | (host_gnt & ~host_ok);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              bus.err_addr <= 1'b0;
      else if (err_set)     bus.err_addr <= 1'b1;
      else if (bus.err_clr) bus.err_addr <= 1'b0;
   end
endmodule

// File: tb/tb_matmul_mem_responder.sv
// Directed bench for matmul_mem_responder: a word-level memory model checked every cycle,
// plus literal expectations at the interesting points of each scenario.
module tb_matmul_mem_responder;
   import matmul_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matmul_mem_responder_if bus();
   matmul_mem_responder u_dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- model ----------------
   logic [31:0] m_mem [3][16];
   logic [31:0] e_a = 0, e_b = 0, e_rdata = 0;
   bit e_rvalid = 0, e_done = 0, e_err = 0, m_resp = 0;
   int m_cnt = 0;

   function automatic bit legal(input logic [9:0] a, input int region);
      int v;
      v = int'(a);
      return (v / 256 == region) && (v % 256 < 16);
   endfunction

   initial begin
      forever begin
         bit gnt, set, done, ok, n_rv;
         int reg_n, idx;
         logic [31:0] n_rd;
         @(posedge clk or posedge rst);
         if (rst) begin
            e_a = 0; e_b = 0; e_rvalid = 0; e_rdata = 0;
            e_done = 0; e_err = 0; m_cnt = 0; m_resp = 0;
         end else begin
            gnt  = bus.host_req && !(bus.mem_read_en_A || bus.mem_read_en_B || bus.mem_write_en_C) && !m_resp;
            set  = 0; done = 0; n_rv = 0; n_rd = 0;
            if (bus.mem_read_en_A) begin
               if (legal(bus.mem_addr_A, 0)) e_a = m_mem[0][int'(bus.mem_addr_A) % 16];
               else begin e_a = 0; set = 1; end
            end
            if (bus.mem_read_en_B) begin
               if (legal(bus.mem_addr_B, 1)) e_b = m_mem[1][int'(bus.mem_addr_B) % 16];
               else begin e_b = 0; set = 1; end
            end
            if (bus.mem_write_en_C) begin
               if (legal(bus.mem_addr_C, 2)) begin
                  m_mem[2][int'(bus.mem_addr_C) % 16] = bus.mem_data_C;
                  m_cnt++;
                  if (m_cnt == 4) begin m_cnt = 0; done = 1; end
               end else set = 1;
            end
            if (gnt) begin
               reg_n = int'(bus.host_addr) / 256;
               idx   = int'(bus.host_addr) % 16;
               ok    = reg_n < 3 && legal(bus.host_addr, reg_n);
               if (!ok) set = 1;
               if (bus.host_we) begin
                  if (ok) m_mem[reg_n][idx] = bus.host_wdata;
               end else begin
                  n_rv = 1;
                  n_rd = ok ? m_mem[reg_n][idx] : 32'h0;
               end
            end
            e_err    = set ? 1'b1 : (bus.err_clr ? 1'b0 : e_err);
            e_rvalid = n_rv;
            e_rdata  = n_rd;
            m_resp   = n_rv;
            e_done   = done;
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         bit e_gnt;
         @(negedge clk);
         e_gnt = bus.host_req && !(bus.mem_read_en_A || bus.mem_read_en_B || bus.mem_write_en_C) && !m_resp;
         chk("m_mem_data_A", bus.mem_data_A, e_a);
         chk("m_mem_data_B", bus.mem_data_B, e_b);
         chk("m_host_gnt", bus.host_gnt, e_gnt);
         chk("m_host_rvalid", bus.host_rvalid, e_rvalid);
         if (e_rvalid) chk("m_host_rdata", bus.host_rdata, e_rdata);
         chk("m_c_done", bus.c_done, e_done);
         chk("m_err_addr", bus.err_addr, e_err);
      end
   end

   // ---------------- stimulus ----------------
   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic idle_in();
      bus.mem_read_en_A = 0; bus.mem_addr_A = 0;
      bus.mem_read_en_B = 0; bus.mem_addr_B = 0;
      bus.mem_write_en_C = 0; bus.mem_addr_C = 0; bus.mem_data_C = 0;
      bus.host_req = 0; bus.host_we = 0; bus.host_addr = 0; bus.host_wdata = 0;
      bus.err_clr = 0;
   endtask

   // Returns just after the granting edge with host_req already dropped.
   task automatic host_op(input bit we, input logic [9:0] addr, input logic [31:0] wd);
      bit g;
      g = 0;
      bus.host_req = 1; bus.host_we = we; bus.host_addr = addr; bus.host_wdata = wd;
      for (int n = 0; n < 8 && !g; n++) begin
         @(negedge clk);
         g = bus.host_gnt;
         sync();
      end
      bus.host_req = 0;
      chk("host_grant_within_budget", g, 1);
   endtask

   task automatic host_read(input logic [9:0] addr, input logic [31:0] exp);
      host_op(0, addr, 0);
      @(negedge clk);
      chk("host_rvalid", bus.host_rvalid, 1);
      chk("host_rdata", bus.host_rdata, exp);
      sync();
   endtask

   initial begin
      idle_in();
      repeat (2) @(negedge clk);
      chk("rst_mem_data_A", bus.mem_data_A, 0);
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_c_done", bus.c_done, 0);
      chk("rst_err_addr", bus.err_addr, 0);
      sync(); rst = 0; sync();

      // Preload and engine read with hold.
      host_op(1, BASE_A, 32'h04030201);
      host_op(1, BASE_B, 32'h01010101);
      bus.mem_read_en_A = 1; bus.mem_addr_A = BASE_A;
      bus.mem_read_en_B = 1; bus.mem_addr_B = BASE_B;
      sync();
      idle_in();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("read_A_hold", bus.mem_data_A, 32'h04030201);
      end
      chk("read_B", bus.mem_data_B, 32'h01010101);
      sync();

      // Four C writes, c_done after the fourth only.
      for (int i = 0; i < 4; i++) begin
         bus.mem_write_en_C = 1; bus.mem_addr_C = BASE_C + 10'(i);
         bus.mem_data_C = 32'h11111111 * (i + 1);
         sync();
         idle_in();
         @(negedge clk);
         chk("c_done_pulse", bus.c_done, (i == 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      chk("c_done_once", bus.c_done, 0);
      sync();
      host_read(10'h202, 32'h33333333);

      // Host read collides with engine read: engine wins, host granted next cycle.
      bus.host_req = 1; bus.host_we = 0; bus.host_addr = BASE_A;
      bus.mem_read_en_A = 1; bus.mem_addr_A = BASE_A;
      @(negedge clk);
      chk("gnt_blocked", bus.host_gnt, 0);
      sync();
      bus.mem_read_en_A = 0;
      @(negedge clk);
      chk("gnt_next", bus.host_gnt, 1);
      sync();
      bus.host_req = 0;
      @(negedge clk);
      chk("stall_rvalid", bus.host_rvalid, 1);
      chk("stall_rdata", bus.host_rdata, 32'h04030201);
      sync();

      // Port/region mismatch: bad A read and dropped C write.
      bus.mem_read_en_A = 1; bus.mem_addr_A = BASE_B;
      bus.mem_write_en_C = 1; bus.mem_addr_C = 10'h010; bus.mem_data_C = 32'hDEADBEEF;
      sync();
      idle_in();
      @(negedge clk);
      chk("err_set", bus.err_addr, 1);
      chk("bad_read_zero", bus.mem_data_A, 0);
      sync();
      host_read(BASE_C, 32'h11111111);
      // Out-of-range B read with err_clr in the same cycle: set wins.
      bus.mem_read_en_B = 1; bus.mem_addr_B = 10'h110; bus.err_clr = 1;
      sync();
      idle_in();
      @(negedge clk);
      chk("err_set_wins", bus.err_addr, 1);
      chk("oor_read_zero", bus.mem_data_B, 0);
      sync();
      bus.err_clr = 1;
      sync();
      bus.err_clr = 0;
      @(negedge clk);
      chk("err_clr", bus.err_addr, 0);
      sync();

      // Illegal host region: read returns 0 with rvalid and raises err.
      host_read(10'h300, 32'h0);
      chk("host_bad_err", bus.err_addr, 1);
      bus.err_clr = 1;
      sync();
      bus.err_clr = 0;

      // Reset landing on the RESP cycle.
      host_op(0, BASE_A, 0);
      rst = 1;
      @(negedge clk);
      chk("rst_resp_rvalid", bus.host_rvalid, 0);
      chk("rst_resp_data_B", bus.mem_data_B, 0);
      chk("rst_resp_err", bus.err_addr, 0);
      sync(); rst = 0; sync();
      host_read(BASE_B, 32'h01010101);
      bus.mem_read_en_A = 1; bus.mem_addr_A = BASE_A;
      sync();
      idle_in();
      @(negedge clk);
      chk("ram_kept_A", bus.mem_data_A, 32'h04030201);
      sync();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1);
   end
endmodule
